// File: rtl/tone_sequencer.sv
// tone_sequencer
// ---------------
// Plays a fixed-length sequence of NUM_TONES tone slots by stepping the address
// of an external sine ROM at a per-slot rate. A slot's divider sets how many
// cycles each ROM address is held (divider + 1). A divider of 0 marks a rest
// slot: the address is frozen and the audio output is silent. Each slot lasts
// DURATION cycles. A latched DURATION of 0 is treated as 1. The sequence can
// play once or repeat.
//
// Ports
//   CLOCK      system clock
//   RESET_N    asynchronous active-low reset
//   START      single-cycle request to begin the sequence (ignored unless idle)
//   STOP       abort playback; wins over START
//   LOOP       1 = repeat the sequence, 0 = play once (sampled at the last slot end)
//   TONE_DIV   per-slot step divider, slot k at [k*DIV_W +: DIV_W]
//   DURATION   cycles spent on each slot
//   SINE_IN    sample returned by the sine ROM for ADDR
//   ADDR       sine ROM address (phase continues across slot changes)
//   AUDIO_OUT  registered sample to the DAC; 0 outside PLAY and in rest slots
//   TONE_IDX   index of the slot currently playing
//   BUSY       high while playing
//   DONE       one-cycle pulse when a play-once sequence completes
module tone_sequencer #(
    parameter int NUM_TONES = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 16,
    parameter int DUR_W     = 26,
    localparam int IDX_W    = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1
) (
    input  logic                       CLOCK,
    input  logic                       RESET_N,
    input  logic                       START,
    input  logic                       STOP,
    input  logic                       LOOP,
    input  logic [NUM_TONES*DIV_W-1:0] TONE_DIV,
    input  logic [DUR_W-1:0]           DURATION,
    input  logic [DATA_W-1:0]          SINE_IN,
    output logic [ADDR_W-1:0]          ADDR,
    output logic [DATA_W-1:0]          AUDIO_OUT,
    output logic [IDX_W-1:0]           TONE_IDX,
    output logic                       BUSY,
    output logic                       DONE
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TONES - 1);

    // Selects the divider of one slot out of the packed divider vector.
    function automatic logic [DIV_W-1:0] slot_div(
        input logic [NUM_TONES*DIV_W-1:0] vec,
        input logic [IDX_W-1:0]           idx
    );
        logic [DIV_W-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_TONES; k++) begin
            if (idx == IDX_W'(k)) begin
                res = vec[k*DIV_W +: DIV_W];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Registered state
    state_t                     state_r;
    logic [ADDR_W-1:0]          addr_r;
    logic [DATA_W-1:0]          audio_r;
    logic [IDX_W-1:0]           idx_r;
    logic [DIV_W-1:0]           step_r;
    logic [DUR_W-1:0]           dur_r;
    logic [NUM_TONES*DIV_W-1:0] div_lat_r;
    logic [DUR_W-1:0]           dur_lat_r;
    logic                       busy_r;
    logic                       done_r;

    // Next-state values
    state_t                     state_nxt_s;
    logic [ADDR_W-1:0]          addr_nxt_s;
    logic [DATA_W-1:0]          audio_nxt_s;
    logic [IDX_W-1:0]           idx_nxt_s;
    logic [DIV_W-1:0]           step_nxt_s;
    logic [DUR_W-1:0]           dur_nxt_s;
    logic [NUM_TONES*DIV_W-1:0] div_lat_nxt_s;
    logic [DUR_W-1:0]           dur_lat_nxt_s;

    // Decodes of the current slot
    logic [DIV_W-1:0]           cur_div_s;
    logic [DIV_W-1:0]           nxt_div_s;
    logic                       rest_s;
    logic                       step_hit_s;
    logic                       slot_end_s;
    logic                       last_slot_s;

    // Current-slot decodes feeding the next-state logic
    always_comb begin
        cur_div_s   = slot_div(div_lat_r, idx_r);
        rest_s      = (cur_div_s == '0);
        step_hit_s  = (step_r == cur_div_s);
        // dur_lat_r is never 0 while playing, so the subtraction cannot wrap
        slot_end_s  = (dur_r == (dur_lat_r - DUR_W'(1)));
        last_slot_s = (idx_r == LAST_IDX);
    end

    // FSM next-state, counter and configuration update
    always_comb begin
        state_nxt_s   = state_r;
        addr_nxt_s    = addr_r;
        idx_nxt_s     = idx_r;
        step_nxt_s    = step_r;
        dur_nxt_s     = dur_r;
        div_lat_nxt_s = div_lat_r;
        dur_lat_nxt_s = dur_lat_r;

        case (state_r)
            ST_IDLE: begin
                if (START && !STOP) begin
                    state_nxt_s   = ST_PLAY;
                    div_lat_nxt_s = TONE_DIV;
                    dur_lat_nxt_s = (DURATION == '0) ? DUR_W'(1) : DURATION;
                    idx_nxt_s     = '0;
                    step_nxt_s    = '0;
                    dur_nxt_s     = '0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end

            ST_PLAY: begin
                if (STOP) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    // A rest slot keeps its address so the next tone resumes in phase
                    if (!rest_s && step_hit_s) begin
                        addr_nxt_s = addr_r + ADDR_W'(1);
                    end else begin
                        addr_nxt_s = addr_r;
                    end

                    if (step_hit_s || slot_end_s) begin
                        step_nxt_s = '0;
                    end else begin
                        step_nxt_s = step_r + DIV_W'(1);
                    end

                    if (slot_end_s) begin
                        dur_nxt_s = '0;
                        if (!last_slot_s) begin
                            idx_nxt_s = idx_r + IDX_W'(1);
                        end else if (LOOP) begin
                            idx_nxt_s = '0;
                        end else begin
                            state_nxt_s = ST_FINISH;
                        end
                    end else begin
                        dur_nxt_s = dur_r + DUR_W'(1);
                    end
                end
            end

            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Audio capture: the sample is taken only when the coming cycle is a
    // non-rest PLAY cycle, so the output is silent for a whole rest slot and
    // drops to 0 together with leaving PLAY.
    always_comb begin
        nxt_div_s = slot_div(div_lat_r, idx_nxt_s);
        if ((state_r == ST_PLAY) && (state_nxt_s == ST_PLAY) && (nxt_div_s != '0)) begin
            audio_nxt_s = SINE_IN;
        end else begin
            audio_nxt_s = '0;
        end
    end

    // State, counter, configuration and output registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            audio_r   <= '0;
            idx_r     <= '0;
            step_r    <= '0;
            dur_r     <= '0;
            div_lat_r <= '0;
            dur_lat_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            addr_r    <= addr_nxt_s;
            audio_r   <= audio_nxt_s;
            idx_r     <= idx_nxt_s;
            step_r    <= step_nxt_s;
            dur_r     <= dur_nxt_s;
            div_lat_r <= div_lat_nxt_s;
            dur_lat_r <= dur_lat_nxt_s;
            busy_r    <= (state_nxt_s == ST_PLAY);
            done_r    <= (state_nxt_s == ST_FINISH);
        end
    end

    assign ADDR      = addr_r;
    assign AUDIO_OUT = audio_r;
    assign TONE_IDX  = idx_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;

endmodule
